trilinear_interp_pipe: RTL
==========================

Name: trilinear_interp_pipe

Overview:
- Pipelined, parametrised trilinear interpolator for the hash-encoding datapath.
- Consumes 8 corner feature vectors (NCH channels each) plus per-axis fractional weights, and produces one interpolated feature vector per accepted request.
- Fixed-point; throughput 1 request/cycle; valid/ready on both sides, so it can sit directly between the hash-table fetch and the MLP input buffer.

Parameters:
- NCH, 2, feature channels per corner (hash-grid feature width F)
- FEAT_W, 16, signed fixed-point feature width (two's complement)
- FRAC_W, 8, unsigned weight width; weight value = w / 2^FRAC_W, range [0,1)
- TAG_W, 8, opaque request tag carried through unchanged

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_feat  in  8*NCH*FEAT_W  corner features; corner c, channel k at slice [(c*NCH+k)*FEAT_W +: FEAT_W]; corner index c = {zbit,ybit,xbit}
- in_wx / in_wy / in_wz  in  FRAC_W each  fractional position along x / y / z
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_feat  out  NCH*FEAT_W  interpolated features, channel k at [k*FEAT_W +: FEAT_W]
- out_tag  out  TAG_W  tag of the result

Behaviour:
- lerp(a,b,w) = a + ((b-a)*w >>> FRAC_W).
  - b-a is computed at FEAT_W+1 bits signed; the product is FEAT_W+FRAC_W+2 bits signed; the shift is arithmetic (floor).
  - The result always lies between a and b inclusive, so truncation to FEAT_W cannot overflow. No saturation logic.
- Stage X (reg 1): per channel, four lerps on corner pairs (0,1) (2,3) (4,5) (6,7) with wx. Register the 4 results, wy, wz and tag.
- Stage Y (reg 2): two lerps, (x01,x23) and (x45,x67), with wy. Register the 2 results, wz and tag.
- Stage Z (reg 3): one lerp, (y0123,y4567), with wz. This register drives out_feat / out_tag.
- Latency: 3 cycles from an in_valid&&in_ready handshake to out_valid, with no stalls.
- Handshake:
  - Each stage has a valid bit. Stage s loads when it is empty or its successor loads in the same cycle.
  - in_ready = ~v1 | (stage 1 advances this cycle). This is combinational from out_ready through the valid chain; no combinational path from in_valid to in_ready.
  - Under continuous out_ready=1 the block sustains 1 result/cycle. With out_ready=0 and all 3 stages full, in_ready=0.
  - A bubble in the middle stages is squeezed out while the output is stalled.
- Output stability: while out_valid=1 and out_ready=0, out_feat and out_tag hold their values.
- Ordering: results emerge in acceptance order.
- Weights: w=0 returns exactly a. The maximum w = 2^FRAC_W-1 never reaches b exactly; a weight of 1.0 is not representable and not supported.
- Reset (rstn low, any time, including mid-stream):
  - All valid bits clear asynchronously; in-flight requests are discarded.
  - out_valid=0, out_feat=0, out_tag=0, all pipeline data registers reset to 0.
  - in_ready=1 in the first cycle after reset deasserts.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.

Optional Feature:
- Macro TRILINEAR_ROUND_EN.
- Defined: each lerp adds 2^(FRAC_W-1) to the product before the arithmetic shift, giving round-half-up. The in-range guarantee still holds.
- Undefined: floor truncation as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package interp_pkg holds:
  - corner-index constants C000..C111
  - a feat_t typedef parameterised by width via a localparam
  - a pure function lerp_fx(a,b,w) implementing the arithmetic, including the TRILINEAR_ROUND_EN branch
- One natural sub-module: interp_lerp_stage. It is a registered stage of N parallel lerps with a valid/ready slice, instantiated three times with N = 4*NCH, 2*NCH, NCH.

Test Plan (FEAT_W=16, FRAC_W=8, NCH=2):
- Constant field: all corners=100, any weights, tag=0x5A -> out_feat both channels 100, tag 0x5A, out_valid exactly 3 cycles after accept.
- X-ramp: even corners 0, odd corners 200, wx=0x80, wy=0x33, wz=0xC0 -> 100.
- Negative floor/round: even corners -3, odd corners 0, wx=0x80 -> -2 default, -1 with TRILINEAR_ROUND_EN.
- Full-corner check: corners c*1000 (c=0..7), wx=wy=wz=0x80 -> 3500 in both builds (all intermediate values exact).
- Backpressure: 10 back-to-back requests, out_ready toggling 1,0,0,1 pattern -> all 10 results in order, outputs stable while stalled, in_ready=0 only when all 3 stages are full.
- Reset mid-stream: 3 requests in flight, pulse rstn low asynchronously -> out_valid drops immediately, no stale results afterwards, next request returns after 3 cycles.

Source files
------------

// File: rtl/trilinear_interp_pipe_pkg.sv
// Shared constants and fixed-point lerp arithmetic for the trilinear interpolator.
// Macro TRILINEAR_ROUND_EN selects round-half-up instead of floor truncation.
package interp_pkg;

    localparam int FEAT_W_DEF = 16;
    typedef logic signed [FEAT_W_DEF-1:0] feat_t;

    // Wide working width: holds any FEAT_W <= 31 feature sign-extended.
    localparam int LERP_W = 32;
    localparam int WT_W   = 16;
    typedef logic signed [LERP_W-1:0] lerp_t;

    // Corner index = {zbit, ybit, xbit}
    localparam int C000 = 0;
    localparam int C001 = 1;
    localparam int C010 = 2;
    localparam int C011 = 3;
    localparam int C100 = 4;
    localparam int C101 = 5;
    localparam int C110 = 6;
    localparam int C111 = 7;

    function automatic lerp_t lerp_fx(input lerp_t a, input lerp_t b,
                                      input logic [WT_W-1:0] w, input int frac);
        logic signed [63:0] d;
        logic signed [63:0] p;
        d = 64'(b) - 64'(a);
        p = d * $signed({48'd0, w});
`ifdef TRILINEAR_ROUND_EN
        p = p + (64'sd1 <<< (frac - 1));
`endif
        p = p >>> frac;
        return LERP_W'(64'(a) + p);
    endfunction

endpackage

// File: rtl/trilinear_interp_pipe_lerp_stage.sv
// One registered stage of N parallel lerps with a valid/ready pipeline slice;
// side-band bits (remaining weights, tag) travel with the data unchanged.
import interp_pkg::*;

module interp_lerp_stage #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int SIDE_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_a,
    input  logic [N*DATA_W-1:0] in_b,
    input  logic [FRAC_W-1:0]   in_w,
    input  logic [SIDE_W-1:0]   in_side,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_y,
    output logic [SIDE_W-1:0]   out_side
);

    logic [N*DATA_W-1:0] y_next;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign y_next[i*DATA_W +: DATA_W] = DATA_W'(lerp_fx(
            LERP_W'($signed(in_a[i*DATA_W +: DATA_W])),
            LERP_W'($signed(in_b[i*DATA_W +: DATA_W])),
            WT_W'(in_w), FRAC_W));
    end

    // Loads when empty or when the successor takes the current contents.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_side  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_y    <= y_next;
                out_side <= in_side;
            end
        end
    end

endmodule

// File: rtl/trilinear_interp_pipe.sv
// Three-stage pipelined trilinear interpolator (x, then y, then z lerps).
// Build macro TRILINEAR_ROUND_EN switches every lerp to round-half-up.
import interp_pkg::*;

module trilinear_interp_pipe #(
    parameter int NCH    = 2,
    parameter int FEAT_W = 16,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NCH*FEAT_W-1:0] in_feat,
    input  logic [FRAC_W-1:0]       in_wx,
    input  logic [FRAC_W-1:0]       in_wy,
    input  logic [FRAC_W-1:0]       in_wz,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*FEAT_W-1:0]   out_feat,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int SIDE1_W = 2*FRAC_W + TAG_W;
    localparam int SIDE2_W = FRAC_W + TAG_W;
    localparam int LO_C [4] = '{C000, C010, C100, C110};
    localparam int HI_C [4] = '{C001, C011, C101, C111};

    logic [4*NCH*FEAT_W-1:0] a_p0, b_p0, x_p1;
    logic [2*NCH*FEAT_W-1:0] a_p1, b_p1, y_p2;
    logic [SIDE1_W-1:0]      side_p1;
    logic [SIDE2_W-1:0]      side_p2;
    logic                    vld_p1, vld_p2, rdy_p2, rdy_p3;
    logic [FRAC_W-1:0]       wy_p1, wz_p1, wz_p2;
    logic [TAG_W-1:0]        tag_p1, tag_p2;

    for (genvar p = 0; p < 4; p++) begin : g_x_pair
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign a_p0[(p*NCH+k)*FEAT_W +: FEAT_W] = in_feat[(LO_C[p]*NCH+k)*FEAT_W +: FEAT_W];
            assign b_p0[(p*NCH+k)*FEAT_W +: FEAT_W] = in_feat[(HI_C[p]*NCH+k)*FEAT_W +: FEAT_W];
        end
    end

    // Stage X: pairs along x, weights wy/wz and tag ride along.
    interp_lerp_stage #(.N(4*NCH), .DATA_W(FEAT_W), .FRAC_W(FRAC_W), .SIDE_W(SIDE1_W)) u_stage_x (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(a_p0), .in_b(b_p0), .in_w(in_wx), .in_side({in_wy, in_wz, in_tag}),
        .out_valid(vld_p1), .out_ready(rdy_p2), .out_y(x_p1), .out_side(side_p1)
    );

    assign wy_p1  = side_p1[TAG_W+FRAC_W +: FRAC_W];
    assign wz_p1  = side_p1[TAG_W +: FRAC_W];
    assign tag_p1 = side_p1[TAG_W-1:0];

    for (genvar q = 0; q < 2; q++) begin : g_y_pair
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign a_p1[(q*NCH+k)*FEAT_W +: FEAT_W] = x_p1[((2*q)*NCH+k)*FEAT_W +: FEAT_W];
            assign b_p1[(q*NCH+k)*FEAT_W +: FEAT_W] = x_p1[((2*q+1)*NCH+k)*FEAT_W +: FEAT_W];
        end
    end

    // Stage Y: (x01,x23) and (x45,x67) along y.
    interp_lerp_stage #(.N(2*NCH), .DATA_W(FEAT_W), .FRAC_W(FRAC_W), .SIDE_W(SIDE2_W)) u_stage_y (
        .clk(clk), .rstn(rstn),
        .in_valid(vld_p1), .in_ready(rdy_p2),
        .in_a(a_p1), .in_b(b_p1), .in_w(wy_p1), .in_side({wz_p1, tag_p1}),
        .out_valid(vld_p2), .out_ready(rdy_p3), .out_y(y_p2), .out_side(side_p2)
    );

    assign wz_p2  = side_p2[TAG_W +: FRAC_W];
    assign tag_p2 = side_p2[TAG_W-1:0];

    // Stage Z: final lerp; its register is the block output.
    interp_lerp_stage #(.N(NCH), .DATA_W(FEAT_W), .FRAC_W(FRAC_W), .SIDE_W(TAG_W)) u_stage_z (
        .clk(clk), .rstn(rstn),
        .in_valid(vld_p2), .in_ready(rdy_p3),
        .in_a(y_p2[NCH*FEAT_W-1:0]), .in_b(y_p2[2*NCH*FEAT_W-1:NCH*FEAT_W]),
        .in_w(wz_p2), .in_side(tag_p2),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_feat), .out_side(out_tag)
    );

endmodule
